// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, default widths and sequencer state encoding.
package alu_pkg;
    localparam int DW_DEF     = 16;
    localparam int CODE_W_DEF = 3;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;
    localparam logic [2:0] ALU_SHL  = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_INC, S_RESP} state_t;
endpackage

// File: rtl/alu_sat_counter.sv
// alu_sat_counter: saturating event counter, sticks at all-ones.
module alu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_count <= '0;
        else if (i_inc && !(&o_count)) o_count <= o_count + W'(1);
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives a combinational 16-bit ALU over one to three passes per request.
// Optional ALU_SEQ_STATS_EN adds saturating op_count/inc_count outputs.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int                 DW       = DW_DEF,
    parameter int                 CODE_W   = CODE_W_DEF,
    parameter logic [CODE_W-1:0]  ADD_CODE = CODE_W'(ALU_ADD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2*DW-1:0]   req_a,
    input  logic [2*DW-1:0]   req_b,
    input  logic [CODE_W-1:0] req_code,
    input  logic              req_wide,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*DW-1:0]   rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [CODE_W-1:0] alu_code,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       op_count,
    output logic [15:0]       inc_count
`endif
);
    state_t              r_state;
    logic [2*DW-1:0]     r_a, r_b, r_data;
    logic [CODE_W-1:0]   r_code, r_alu_code;
    logic [DW-1:0]       r_alu_a, r_alu_b;
    logic                r_wide, r_lo_carry, r_lo_zero, r_hi_carry;
    logic                r_req_ready, r_rsp_valid, r_rsp_carry, r_rsp_zero;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_code  = r_alu_code;

    // ALU operands are registered one state ahead so they are stable for the whole pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_code      <= '0;
            r_wide      <= 1'b0;
            r_data      <= '0;
            r_lo_carry  <= 1'b0;
            r_lo_zero   <= 1'b0;
            r_hi_carry  <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_code  <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_a         <= req_a;
                    r_b         <= req_b;
                    r_code      <= req_code;
                    r_wide      <= req_wide;
                    r_alu_a     <= req_a[DW-1:0];
                    r_alu_b     <= req_b[DW-1:0];
                    r_alu_code  <= req_code;
                    r_req_ready <= 1'b0;
                    r_state     <= S_LO;
                end
                S_LO: begin
                    r_data[DW-1:0] <= alu_out;
                    r_lo_carry     <= alu_carry;
                    r_lo_zero      <= alu_zero;
                    if (r_wide) begin
                        r_alu_a <= r_a[2*DW-1:DW];
                        r_alu_b <= r_b[2*DW-1:DW];
                        r_state <= S_HI;
                    end else begin
                        r_data[2*DW-1:DW] <= '0;
                        r_rsp_carry       <= alu_carry;
                        r_rsp_zero        <= alu_zero;
                        r_rsp_valid       <= 1'b1;
                        r_alu_a           <= '0;
                        r_alu_b           <= '0;
                        r_alu_code        <= '0;
                        r_state           <= S_RESP;
                    end
                end
                S_HI: begin
                    r_data[2*DW-1:DW] <= alu_out;
                    r_hi_carry        <= alu_carry;
                    if (r_code == ADD_CODE && r_lo_carry) begin
                        r_alu_a    <= alu_out;
                        r_alu_b    <= DW'(1);
                        r_alu_code <= ADD_CODE;
                        r_state    <= S_INC;
                    end else begin
                        r_rsp_carry <= alu_carry;
                        r_rsp_zero  <= r_lo_zero & alu_zero;
                        r_rsp_valid <= 1'b1;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_code  <= '0;
                        r_state     <= S_RESP;
                    end
                end
                S_INC: begin
                    r_data[2*DW-1:DW] <= alu_out;
                    r_rsp_carry       <= r_hi_carry | alu_carry;
                    r_rsp_zero        <= r_lo_zero & alu_zero;
                    r_rsp_valid       <= 1'b1;
                    r_alu_a           <= '0;
                    r_alu_b           <= '0;
                    r_alu_code        <= '0;
                    r_state           <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic w_op_done, w_inc_pass;
    assign w_op_done  = (r_state == S_RESP) && rsp_ready;
    assign w_inc_pass = (r_state == S_INC);
    alu_sat_counter #(.W(16)) u_op_cnt  (.clk(clk), .rst_n(rst_n), .i_inc(w_op_done),  .o_count(op_count));
    alu_sat_counter #(.W(16)) u_inc_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_inc_pass), .o_count(inc_count));
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a behavioural ALU and a 32-bit reference model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wide = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, rsp_data;
    logic [2:0]  req_code = '0, alu_code;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_carry, rsp_zero;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_carry, alu_zero;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count, inc_count;
`endif

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_code(req_code), .req_wide(req_wide),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
`ifdef ALU_SEQ_STATS_EN
        , .op_count(op_count), .inc_count(inc_count)
`endif
    );

    function automatic logic [16:0] alu_fn(input logic [15:0] x, input logic [15:0] y, input logic [2:0] c);
        case (c)
            ALU_ADD: return {1'b0, x} + {1'b0, y};
            ALU_SUB: return {x < y, x - y};
            ALU_AND: return {1'b0, x & y};
            ALU_OR:  return {1'b0, x | y};
            ALU_XOR: return {1'b0, x ^ y};
            ALU_NOT: return {1'b0, ~x};
            ALU_SHL: return {x, 1'b0};
            default: return {1'b0, x};
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_code);
        alu_zero = (alu_out == 16'h0);
    end

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0, fails = 0, cyc = 0, acc_cyc = 0, lat = 0, n_ops = 0, n_inc = 0;
    logic prev_valid = 1'b0;
    bit bp_mode = 1'b1;

    // Wide ADD is a true 32-bit add; other wide codes act on each half independently.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] code, input bit wide);
        exp_t e;
        logic [32:0] s;
        logic [16:0] lo, hi;
        lo = alu_fn(a[15:0], b[15:0], code);
        hi = alu_fn(a[31:16], b[31:16], code);
        if (!wide) begin
            e.data = {16'h0, lo[15:0]};
            e.carry = lo[16];
            e.lat = 1;
        end else if (code == ALU_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            e.data = s[31:0];
            e.carry = s[32];
            e.lat = lo[16] ? 3 : 2;
        end else begin
            e.data = {hi[15:0], lo[15:0]};
            e.carry = hi[16];
            e.lat = 2;
        end
        e.zero = (e.data == 32'h0);
        return e;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (rst_n) begin
            chk(!(req_ready && rsp_valid), "ready_valid_overlap", {req_ready, rsp_valid}, 0);
            if (req_valid && req_ready) acc_cyc = cyc;
            if (rsp_valid && !prev_valid) lat = cyc - acc_cyc - 1;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk(1'b0, "unexpected_rsp", rsp_data, 0);
                else begin
                    e = sb.pop_front();
                    chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
                    chk(rsp_carry == e.carry, "rsp_carry", rsp_carry, e.carry);
                    chk(rsp_zero == e.zero, "rsp_zero", rsp_zero, e.zero);
                    chk(lat == e.lat, "latency", lat, e.lat);
                    n_ops++;
                    if (e.lat == 3) n_inc++;
                end
            end
        end
        prev_valid = rsp_valid;
    end

    initial begin : rsp_ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] code, input bit wide);
        int n = 0;
        req_a = a; req_b = b; req_code = code; req_wide = wide; req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) begin
            chk(1'b0, "accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back(model(a, b, code, wide));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk(1'b0, "drain_timeout", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_half();
        case ($urandom_range(0, 3))
            0: return 16'hFFFF;
            1: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : main
        logic [31:0] d;
        logic c, z;
        int n;
        #12;
        chk(req_ready == 1'b1, "rst_req_ready", req_ready, 1);
        chk({rsp_valid, rsp_carry, rsp_zero} == 3'b0, "rst_rsp_flags", {rsp_valid, rsp_carry, rsp_zero}, 0);
        chk(rsp_data == 32'h0, "rst_rsp_data", rsp_data, 0);
        chk({alu_a, alu_b, alu_code} == '0, "rst_alu_outs", {alu_a, alu_b, alu_code}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'd2, 32'd5, ALU_ADD, 1'b0);
        chk({alu_a, alu_b, alu_code} == {16'd2, 16'd5, ALU_ADD}, "lo_alu_drive", {alu_a, alu_b, alu_code}, {16'd2, 16'd5, ALU_ADD});
        drain();
        send(32'h0000FFFF, 32'h00000001, ALU_ADD, 1'b1);
        drain();
        send(32'hFFFFFFFF, 32'h00000001, ALU_ADD, 1'b1);
        drain();
        send(32'h0F0F1234, 32'h00FF1234, ALU_SUB, 1'b1);
        drain();

        rsp_ready = 1'b0;
        send(32'h12345678, 32'h11111111, ALU_XOR, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(rsp_valid, "bp_rsp_valid", rsp_valid, 1);
        d = rsp_data; c = rsp_carry; z = rsp_zero;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk({rsp_valid, req_ready} == 2'b10, "bp_handshake_flags", {rsp_valid, req_ready}, 2'b10);
            chk({rsp_data, rsp_carry, rsp_zero} == {d, c, z}, "bp_stable", {rsp_data, rsp_carry, rsp_zero}, {d, c, z});
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        send(32'h0001FFFF, 32'h00000001, ALU_ADD, 1'b1);
        @(posedge clk);
        #1;
        chk({alu_a, alu_b} == {16'h0001, 16'h0000}, "hi_alu_drive", {alu_a, alu_b}, {16'h0001, 16'h0000});
        #1 rst_n = 1'b0;
        #1;
        chk({req_ready, rsp_valid} == 2'b10, "midrst_flags", {req_ready, rsp_valid}, 2'b10);
        chk({rsp_data, rsp_carry, rsp_zero} == '0, "midrst_rsp", {rsp_data, rsp_carry, rsp_zero}, 0);
        chk({alu_a, alu_b, alu_code} == '0, "midrst_alu", {alu_a, alu_b, alu_code}, 0);
        sb.delete();
        n_ops = 0;
        n_inc = 0;
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk(!rsp_valid && req_ready, "abandoned_no_rsp", {rsp_valid, req_ready}, 2'b01);
        end
        @(posedge clk);
        #1;

        send(32'h00000003, 32'h00000004, ALU_AND, 1'b0);
        send(32'h8000FFFF, 32'h00010002, ALU_ADD, 1'b1);
        send(32'hAAAA5555, 32'h0000FFFF, ALU_OR, 1'b1);
        drain();
`ifdef ALU_SEQ_STATS_EN
        chk(op_count == 16'(n_ops), "op_count_dir", op_count, n_ops);
        chk(inc_count == 16'(n_inc), "inc_count_dir", inc_count, n_inc);
`endif

        bp_mode = 1'b0;
        for (int i = 0; i < 150; i++) begin
            logic [2:0] code;
            code = ($urandom_range(0, 2) == 0) ? 3'($urandom) : ALU_ADD;
            send({rnd_half(), rnd_half()}, {rnd_half(), rnd_half()}, code, 1'($urandom_range(0, 1)));
        end
        drain();
`ifdef ALU_SEQ_STATS_EN
        chk(op_count == 16'(n_ops), "op_count", op_count, n_ops);
        chk(inc_count == 16'(n_inc), "inc_count", inc_count, n_inc);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
